// File: rtl/wbs_debug_mirror.sv
// Snoops acknowledged Wishbone slave transactions into a small FIFO and replays
// each one on the user GPIO pads for HOLD_CYCLES clocks, with a toggling marker.
module wbs_debug_mirror #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic        wb_clk_i,
    input  logic        resetb,
    input  logic        mirror_en,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] snoop_rdata,
    input  logic        snoop_ack,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [7:0]  overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_ZERO  = {(AW + 1){1'b0}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Entry layout matches io_out[32:0]: {we, adr[15:0], data[15:0]}
    logic [32:0]   mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [0:0]    state_r;
    logic [HW-1:0] hold_cnt_r;
    logic [32:0]   pin_r;
    logic          marker_r;
    logic [33:0]   oeb_r;
    logic [7:0]    overflow_cnt_r;

    logic          full_s;
    logic          empty_s;
    logic          capture_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [32:0]   entry_s;
    logic          unused_bits_s;

    assign unused_bits_s = ^{wbs_adr_i[31:16], wbs_dat_i[31:16], snoop_rdata[31:16]};

    // FIFO status, capture qualification and replay pop decision
    always_comb begin
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty_s   = (wr_ptr_r == rd_ptr_r);
        capture_s = wbs_cyc_i & wbs_stb_i & snoop_ack & mirror_en;
        entry_s   = {wbs_we_i, wbs_adr_i[15:0],
                     wbs_we_i ? wbs_dat_i[15:0] : snoop_rdata[15:0]};
        pop_s     = 1'b0;
        if (mirror_en && !empty_s) begin
            case (state_r)
                ST_IDLE: pop_s = 1'b1;
                ST_HOLD: pop_s = (hold_cnt_r == HOLD_ZERO);
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
        // A full FIFO still accepts a push when the replay side frees a slot this edge
        push_s = capture_s && (!full_s || pop_s);
        drop_s = capture_s && full_s && !pop_s;
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
        end
    end

    // Pointers, replay FSM, pin registers and overflow counter
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_r       <= PTR_ZERO;
            rd_ptr_r       <= PTR_ZERO;
            state_r        <= ST_IDLE;
            hold_cnt_r     <= HOLD_ZERO;
            pin_r          <= 33'd0;
            marker_r       <= 1'b0;
            oeb_r          <= {34{1'b1}};
            overflow_cnt_r <= 8'd0;
        end else begin
            oeb_r <= {34{~mirror_en}};
            if (drop_s && (overflow_cnt_r != 8'hFF)) begin
                overflow_cnt_r <= overflow_cnt_r + 8'd1;
            end
            if (!mirror_en) begin
                wr_ptr_r   <= PTR_ZERO;
                rd_ptr_r   <= PTR_ZERO;
                state_r    <= ST_IDLE;
                hold_cnt_r <= HOLD_ZERO;
                pin_r      <= 33'd0;
                marker_r   <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                    pin_r      <= mem_r[rd_ptr_r[AW-1:0]];
                    marker_r   <= ~marker_r;
                    hold_cnt_r <= HOLD_LOAD;
                    state_r    <= ST_HOLD;
                end else begin
                    case (state_r)
                        ST_IDLE: state_r <= ST_IDLE;
                        ST_HOLD: begin
                            // Counter exhausted with nothing queued: last entry stays on the pins
                            if (hold_cnt_r != HOLD_ZERO) begin
                                hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                        default: state_r <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign io_out       = {4'b0000, marker_r, pin_r};
    assign io_oeb       = {4'b1111, oeb_r};
    assign overflow_cnt = overflow_cnt_r;

endmodule

// File: tb/tb_wbs_debug_mirror.sv
// Directed and random stimulus for wbs_debug_mirror, checked against a
// queue-based model of the capture/replay behaviour.
module tb_wbs_debug_mirror;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic        wb_clk_i = 1'b0;
    logic        resetb = 1'b0;
    logic        mirror_en = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = 32'd0;
    logic [31:0] wbs_dat_i = 32'd0;
    logic [31:0] snoop_rdata = 32'd0;
    logic        snoop_ack = 1'b0;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [7:0]  overflow_cnt;

    wbs_debug_mirror #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .wb_clk_i(wb_clk_i), .resetb(resetb), .mirror_en(mirror_en),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .snoop_rdata(snoop_rdata),
        .snoop_ack(snoop_ack), .io_out(io_out), .io_oeb(io_oeb),
        .overflow_cnt(overflow_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: pending queue, remaining display cycles of the shown entry
    logic [32:0] mq[$];
    int          m_left = 0;
    logic [32:0] m_pins = 33'd0;
    logic        m_marker = 1'b0;
    logic        m_oe = 1'b0;
    int          m_ovf = 0;

    task automatic model_reset();
        mq.delete();
        m_left = 0; m_pins = 33'd0; m_marker = 1'b0; m_oe = 1'b0; m_ovf = 0;
    endtask

    task automatic model_edge();
        logic cap;
        logic pop;
        if (!mirror_en) begin
            mq.delete();
            m_left = 0; m_pins = 33'd0; m_marker = 1'b0; m_oe = 1'b0;
            return;
        end
        m_oe = 1'b1;
        cap = wbs_cyc_i && wbs_stb_i && snoop_ack;
        pop = (mq.size() > 0) && (m_left <= 1);
        if (pop) begin
            m_pins = mq.pop_front();
            m_marker = ~m_marker;
            m_left = HOLD;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
        if (cap) begin
            if (mq.size() < DEPTH)
                mq.push_back({wbs_we_i, wbs_adr_i[15:0],
                              wbs_we_i ? wbs_dat_i[15:0] : snoop_rdata[15:0]});
            else if (m_ovf < 255)
                m_ovf = m_ovf + 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [37:0] exp_out;
        logic [37:0] exp_oeb;
        exp_out = {4'b0000, m_marker, m_pins};
        exp_oeb = {4'b1111, {34{~m_oe}}};
        n_checks++;
        assert (io_out === exp_out) else begin
            n_fail++; $error("FAIL %s io_out got %h expected %h", tag, io_out, exp_out);
        end
        n_checks++;
        assert (io_oeb === exp_oeb) else begin
            n_fail++; $error("FAIL %s io_oeb got %h expected %h", tag, io_oeb, exp_oeb);
        end
        n_checks++;
        assert (overflow_cnt === 8'(m_ovf)) else begin
            n_fail++; $error("FAIL %s overflow_cnt got %0d expected %0d", tag, overflow_cnt, m_ovf);
        end
    endtask

    task automatic check_val(input string tag, input logic [37:0] got, input logic [37:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++; $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, let DUT and model take the edge, compare at the falling edge
    task automatic step(input logic ack, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [31:0] rd, input string tag);
        wbs_cyc_i = ack; wbs_stb_i = ack; snoop_ack = ack;
        wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; snoop_rdata = rd;
        @(posedge wb_clk_i);
        model_edge();
        @(negedge wb_clk_i);
        check_model(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, tag);
    endtask

    initial begin
        logic        mk;
        int          toggles;
        logic        prev;
        logic [31:0] r;

        // Reset with the mirror disabled
        model_reset();
        #12;
        check_val("rst_out", io_out, 38'd0);
        check_val("rst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        check_val("rst_ovf", {30'd0, overflow_cnt}, 38'd0);
        @(negedge wb_clk_i);
        resetb = 1'b1;
        step(1'b1, 1'b1, 32'h3000_0004, 32'h0000_A5A5, 32'd0, "dis_wr");
        idle(4, "dis_idle");
        check_val("dis_out", io_out, 38'd0);

        // Single write, two-edge latency, 8-cycle hold, persists while idle
        mirror_en = 1'b1;
        idle(2, "en_idle");
        step(1'b1, 1'b1, 32'h3000_1234, 32'h0000_BEEF, 32'd0, "wr_ack");
        idle(1, "wr_lat");
        check_val("wr_pins", {5'd0, io_out[32:0]}, {5'd0, 33'h1_1234_BEEF});
        check_val("wr_marker", {37'd0, io_out[33]}, 38'd1);
        idle(7, "wr_hold");
        check_val("wr_held", {5'd0, io_out[32:0]}, {5'd0, 33'h1_1234_BEEF});
        idle(6, "wr_persist");
        check_val("wr_persist", io_out, {4'd0, 1'b1, 33'h1_1234_BEEF});

        // Read transaction captures snoop_rdata
        step(1'b1, 1'b0, 32'h3000_0010, 32'h0000_FFFF, 32'h0000_5A5A, "rd_ack");
        idle(1, "rd_lat");
        check_val("rd_data", {22'd0, io_out[15:0]}, {22'd0, 16'h5A5A});
        check_val("rd_we", {37'd0, io_out[32]}, 38'd0);
        idle(10, "rd_drain");

        // Six back-to-back acks: five replayed, one dropped
        for (int i = 0; i < 6; i++)
            step(1'b1, i[0], 32'h3000_0100 + 32'(i), 32'h0000_1000 + 32'(i),
                 32'h0000_2000 + 32'(i), "burst");
        prev = io_out[33];
        toggles = 0;
        for (int i = 0; i < 50; i++) begin
            idle(1, "burst_drain");
            if (io_out[33] !== prev) toggles++;
            prev = io_out[33];
        end
        check_val("burst_ovf", {30'd0, overflow_cnt}, 38'd1);
        check_val("burst_toggles", 38'(toggles), 38'd4);

        // Two identical writes: marker distinguishes them, no gap cycle
        step(1'b1, 1'b1, 32'h0000_0010, 32'h0000_1111, 32'd0, "same1");
        step(1'b1, 1'b1, 32'h0000_0010, 32'h0000_1111, 32'd0, "same2");
        check_val("same_first", {5'd0, io_out[32:0]}, {5'd0, 33'h1_0010_1111});
        mk = io_out[33];
        idle(7, "same_hold");
        check_val("same_hold_mk", {37'd0, io_out[33]}, {37'd0, mk});
        idle(1, "same_next");
        check_val("same_next_mk", {37'd0, io_out[33]}, {37'd0, ~mk});
        check_val("same_next_pins", {5'd0, io_out[32:0]}, {5'd0, 33'h1_0010_1111});
        idle(10, "same_drain");

        // Random traffic with occasional short disables
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if (r[31:25] == 7'd0) mirror_en = 1'b0;
            else if (r[24:22] != 3'd0) mirror_en = 1'b1;
            wbs_stb_i = 1'b1;
            step(r[2:0] < 3'd2 || (r[21:19] == 3'd0 && i[4]), r[3], $urandom,
                 $urandom, $urandom, "rand");
        end
        mirror_en = 1'b1;
        idle(60, "rand_drain");

        // Disable mid-hold with three entries queued
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 32'h0000_0200 + 32'(i), 32'h0000_3300 + 32'(i), 32'd0, "q4");
        idle(2, "q_hold");
        mirror_en = 1'b0;
        idle(1, "dis_mid");
        check_val("dis_mid_out", {4'd0, io_out[33:0]}, 38'd0);
        check_val("dis_mid_oeb", {4'd0, io_oeb[33:0]}, {4'd0, {34{1'b1}}});
        mirror_en = 1'b1;
        idle(20, "reen");
        check_val("reen_clean", io_out, 38'd0);

        // Asynchronous reset in the middle of a hold
        step(1'b1, 1'b1, 32'h0000_0300, 32'h0000_7777, 32'd0, "pre_rst");
        idle(3, "pre_rst_hold");
        #2 resetb = 1'b0;
        #1;
        check_val("arst_out", io_out, 38'd0);
        check_val("arst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        check_val("arst_ovf", {30'd0, overflow_cnt}, 38'd0);
        model_reset();
        @(negedge wb_clk_i);
        resetb = 1'b1;
        step(1'b1, 1'b0, 32'h0000_0400, 32'd0, 32'h0000_4242, "post_rst");
        idle(12, "post_rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
